// File: rtl/systolic_pkg.sv
// Shared constants and types for the 2x2 systolic mesh feeder.
package systolic_pkg;

    localparam int DEF_DW           = 8;
    localparam int DEF_CW           = 16;
    localparam int DEF_DRAIN_CYCLES = 3;

    // Number of cycles needed to push a skewed 2x2 operand pair into the mesh edges.
    localparam int FEED_LEN = 3;
    // Width of the feed-step index handed to the skew lines (covers 0..FEED_LEN-1).
    localparam int FEED_T_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // The feed and drain phases share one step counter; size it for the longer phase.
    function automatic int step_cnt_width(input int drain_cycles);
        int longest;
        longest = (drain_cycles > FEED_LEN) ? drain_cycles : FEED_LEN;
        return (longest < 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/systolic_skew_line.sv
// One mesh edge (two lanes). Lane 1 lags lane 0 by one step, which produces the
// diagonal wavefront an output-stationary mesh needs. Each lane presents its
// first element and then its second element on consecutive steps, and drives 0
// whenever it has no element to present.
module systolic_skew_line
    import systolic_pkg::*;
#(
    parameter int DW = DEF_DW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_en,
    input  logic [FEED_T_W-1:0] i_t,
    input  logic [DW-1:0]       i_l0_k0,
    input  logic [DW-1:0]       i_l0_k1,
    input  logic [DW-1:0]       i_l1_k0,
    input  logic [DW-1:0]       i_l1_k1,
    output logic [DW-1:0]       o_lane0,
    output logic [DW-1:0]       o_lane1
);

    logic [DW-1:0] r_lane0;
    logic [DW-1:0] r_lane1;

    // Register the edge value for the step the feeder is about to enter.
    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values; blocking here would create ordering-dependent races.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lane0 <= '0;
            r_lane1 <= '0;
        end else if (!i_en) begin
            r_lane0 <= '0;
            r_lane1 <= '0;
        end else begin
            case (i_t)
                FEED_T_W'(0): begin
                    r_lane0 <= i_l0_k0;
                    r_lane1 <= '0;
                end
                FEED_T_W'(1): begin
                    r_lane0 <= i_l0_k1;
                    r_lane1 <= i_l1_k0;
                end
                FEED_T_W'(2): begin
                    r_lane0 <= '0;
                    r_lane1 <= i_l1_k1;
                end
                default: begin
                    r_lane0 <= '0;
                    r_lane1 <= '0;
                end
            endcase
        end
    end

    assign o_lane0 = r_lane0;
    assign o_lane1 = r_lane1;

endmodule

// File: rtl/systolic_feeder.sv
// Host-side sequencer for a 2x2 output-stationary systolic mesh. It takes one
// A/B operand pair, clears the mesh, streams skewed rows of A and columns of B
// into the mesh edges, waits for the accumulators to settle, captures C and
// offers it downstream through a valid/ready handshake.
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int DW           = DEF_DW,
    parameter int CW           = DEF_CW,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a00,
    input  logic [DW-1:0] a01,
    input  logic [DW-1:0] a10,
    input  logic [DW-1:0] a11,
    input  logic [DW-1:0] b00,
    input  logic [DW-1:0] b01,
    input  logic [DW-1:0] b10,
    input  logic [DW-1:0] b11,
    output logic          arr_clr,
    output logic [DW-1:0] arr_a0,
    output logic [DW-1:0] arr_a1,
    output logic [DW-1:0] arr_b0,
    output logic [DW-1:0] arr_b1,
    input  logic [CW-1:0] c00,
    input  logic [CW-1:0] c01,
    input  logic [CW-1:0] c10,
    input  logic [CW-1:0] c11,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [CW-1:0] r00,
    output logic [CW-1:0] r01,
    output logic [CW-1:0] r10,
    output logic [CW-1:0] r11
);

    localparam int CNT_W = step_cnt_width(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic [DW-1:0] r_a00, r_a01, r_a10, r_a11;
    logic [DW-1:0] r_b00, r_b01, r_b10, r_b11;
    logic [CW-1:0] r_c00, r_c01, r_c10, r_c11;

    logic w_accept;
    logic w_capture;
    logic w_feed_en;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_capture = (r_state == ST_DRAIN) && (w_state_nxt == ST_DONE);
    assign w_feed_en = (w_state_nxt == ST_FEED);

    // Next-state and step-counter decode for the job sequence.
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                w_state_nxt = ST_FEED;
                w_cnt_nxt   = '0;
            end
            ST_FEED: begin
                if (r_cnt == FEED_LAST) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and step counter; reset aborts any job in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Operand latch, loaded only when a job is accepted.
    // NOTE: the operand holding registers carry no reset; they are always
    // written before use, so resetting them would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a00 <= a00;
            r_a01 <= a01;
            r_a10 <= a10;
            r_a11 <= a11;
            r_b00 <= b00;
            r_b01 <= b01;
            r_b10 <= b10;
            r_b11 <= b11;
        end
    end

    // Result register: captures the settled accumulators on entry to DONE and
    // keeps them after the handshake.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_c00 <= '0;
            r_c01 <= '0;
            r_c10 <= '0;
            r_c11 <= '0;
        end else if (w_capture) begin
            r_c00 <= c00;
            r_c01 <= c01;
            r_c10 <= c10;
            r_c11 <= c11;
        end
    end

    // A edge: lane 0 is row 0 (a00 then a01), lane 1 is row 1 (a10 then a11).
    systolic_skew_line #(
        .DW (DW)
    ) u_skew_a (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_feed_en),
        .i_t     (w_cnt_nxt[FEED_T_W-1:0]),
        .i_l0_k0 (r_a00),
        .i_l0_k1 (r_a01),
        .i_l1_k0 (r_a10),
        .i_l1_k1 (r_a11),
        .o_lane0 (arr_a0),
        .o_lane1 (arr_a1)
    );

    // B edge: lane 0 is column 0 (b00 then b10), lane 1 is column 1 (b01 then b11).
    systolic_skew_line #(
        .DW (DW)
    ) u_skew_b (
        .clk     (clk),
        .reset   (reset),
        .i_en    (w_feed_en),
        .i_t     (w_cnt_nxt[FEED_T_W-1:0]),
        .i_l0_k0 (r_b00),
        .i_l0_k1 (r_b10),
        .i_l1_k0 (r_b01),
        .i_l1_k1 (r_b11),
        .o_lane0 (arr_b0),
        .o_lane1 (arr_b1)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign arr_clr   = (r_state == ST_CLEAR);
    assign res_valid = (r_state == ST_DONE);
    assign r00       = r_c00;
    assign r01       = r_c01;
    assign r10       = r_c10;
    assign r11       = r_c11;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: wraps a behavioural 2x2 output-stationary mesh on
// the edge ports and compares results against a plain matrix product.
module tb_systolic_feeder;

    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int DRAIN = 3;
    localparam int LAT   = 1 + 3 + DRAIN + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a00, a01, a10, a11;
    logic [DW-1:0] b00, b01, b10, b11;
    logic          arr_clr;
    logic [DW-1:0] arr_a0, arr_a1, arr_b0, arr_b1;
    logic [CW-1:0] c00, c01, c10, c11;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] r00, r01, r10, r11;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    systolic_feeder #(
        .DW           (DW),
        .CW           (CW),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a00       (a00),
        .a01       (a01),
        .a10       (a10),
        .a11       (a11),
        .b00       (b00),
        .b01       (b01),
        .b10       (b10),
        .b11       (b11),
        .arr_clr   (arr_clr),
        .arr_a0    (arr_a0),
        .arr_a1    (arr_a1),
        .arr_b0    (arr_b0),
        .arr_b1    (arr_b1),
        .c00       (c00),
        .c01       (c01),
        .c10       (c10),
        .c11       (c11),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .r00       (r00),
        .r01       (r01),
        .r10       (r10),
        .r11       (r11)
    );

    // Behavioural mesh: A moves right, B moves down, each PE accumulates a*b.
    logic [DW-1:0] m_ar [2][2];
    logic [DW-1:0] m_br [2][2];
    logic [CW-1:0] m_acc[2][2];
    logic [DW-1:0] m_ai, m_bi;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                m_ai = (j == 0) ? ((i == 0) ? arr_a0 : arr_a1) : m_ar[i][0];
                m_bi = (i == 0) ? ((j == 0) ? arr_b0 : arr_b1) : m_br[0][j];
                if (arr_clr) begin
                    m_acc[i][j] <= '0;
                    m_ar[i][j]  <= '0;
                    m_br[i][j]  <= '0;
                end else begin
                    m_acc[i][j] <= m_acc[i][j] + ({8'd0, m_ai} * {8'd0, m_bi});
                    m_ar[i][j]  <= m_ai;
                    m_br[i][j]  <= m_bi;
                end
            end
        end
    end

    assign c00 = m_acc[0][0];
    assign c01 = m_acc[0][1];
    assign c10 = m_acc[1][0];
    assign c11 = m_acc[1][1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] edge_now();
        return {arr_a0, arr_a1, arr_b0, arr_b1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ops(input logic [31:0] av, input logic [31:0] bv);
        {a00, a01, a10, a11} = av;
        {b00, b01, b10, b11} = bv;
    endtask

    // One complete job: av/bv are row-major {x00,x01,x10,x11}; hold = cycles
    // res_ready stays low once the result is offered.
    task automatic run_job(input logic [31:0] av, input logic [31:0] bv, input int hold);
        logic [DW-1:0] ea[4];
        logic [DW-1:0] eb[4];
        logic [CW-1:0] er[4];
        logic [31:0]   exp_edge[3];
        int            s;
        int            cyc;

        for (int k = 0; k < 4; k++) begin
            ea[k] = av[31-8*k -: 8];
            eb[k] = bv[31-8*k -: 8];
        end
        s = ea[0]*eb[0] + ea[1]*eb[2]; er[0] = s[15:0];
        s = ea[0]*eb[1] + ea[1]*eb[3]; er[1] = s[15:0];
        s = ea[2]*eb[0] + ea[3]*eb[2]; er[2] = s[15:0];
        s = ea[2]*eb[1] + ea[3]*eb[3]; er[3] = s[15:0];
        exp_edge[0] = {ea[0], 8'd0, eb[0], 8'd0};
        exp_edge[1] = {ea[1], ea[2], eb[2], eb[1]};
        exp_edge[2] = {8'd0, ea[3], 8'd0, eb[3]};

        check("idle_ready", 32'(in_ready), 32'd1);
        res_ready = (hold == 0);
        drive_ops(av, bv);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < LAT + 20) begin
            check("busy_not_ready", 32'(in_ready), 32'd0);
            if (cyc == 1) begin
                check("clr_pulse", 32'(arr_clr), 32'd1);
                check("edge_clear", edge_now(), 32'd0);
            end else if (cyc <= 4) begin
                check("clr_low_feed", 32'(arr_clr), 32'd0);
                check("edge_feed", edge_now(), exp_edge[cyc-2]);
            end else begin
                check("edge_drain", edge_now(), 32'd0);
            end
            // Operands changing after acceptance must not disturb the job.
            drive_ops($urandom, $urandom);
            step();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(LAT));
        check("r00", 32'(r00), 32'(er[0]));
        check("r01", 32'(r01), 32'(er[1]));
        check("r10", 32'(r10), 32'(er[2]));
        check("r11", 32'(r11), 32'(er[3]));

        for (int h = 0; h < hold; h++) begin
            drive_ops($urandom, $urandom);
            in_valid = 1'b1;
            step();
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_not_ready", 32'(in_ready), 32'd0);
            check("hold_r", {r00, r01}, {er[0], er[1]});
            check("hold_r_lo", {r10, r11}, {er[2], er[3]});
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        step();
        check("post_hs_valid", 32'(res_valid), 32'd0);
        check("post_hs_ready", 32'(in_ready), 32'd1);
        check("post_hs_r", {r00, r11}, {er[0], er[3]});
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b0;
        drive_ops('0, '0);
        step();
        step();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_clr", 32'(arr_clr), 32'd0);
        check("rst_edge", edge_now(), 32'd0);
        check("rst_r", {r00, r01}, 32'd0);
        check("rst_r_lo", {r10, r11}, 32'd0);
        reset = 1'b1;
        step();

        // Reference job, then all-max operands (wraps modulo 2^CW).
        run_job({8'd2, 8'd3, 8'd4, 8'd5}, {8'd6, 8'd7, 8'd8, 8'd9}, 0);
        check("ref_r00", 32'(r00), 32'd36);
        check("ref_r11", 32'(r11), 32'd73);
        run_job(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("max_wrap", 32'(r10), 32'd64514);

        // Downstream stall for 5 cycles with in_valid pushed during the stall.
        run_job({8'd1, 8'd2, 8'd3, 8'd4}, {8'd5, 8'd6, 8'd7, 8'd8}, 5);

        // Back-to-back jobs.
        run_job({8'd1, 8'd0, 8'd0, 8'd1}, {8'd1, 8'd2, 8'd3, 8'd4}, 0);
        run_job({8'd2, 8'd3, 8'd4, 8'd5}, {8'd1, 8'd0, 8'd0, 8'd1}, 0);

        // Reset in the middle of FEED (step t=1): job is abandoned.
        res_ready = 1'b1;
        drive_ops({8'd9, 8'd9, 8'd9, 8'd9}, {8'd7, 8'd7, 8'd7, 8'd7});
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        check("mid_feed_edge", edge_now(), {8'd9, 8'd9, 8'd7, 8'd7});
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_valid", 32'(res_valid), 32'd0);
        check("abort_edge", edge_now(), 32'd0);
        check("abort_clr", 32'(arr_clr), 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            check("abort_no_result", 32'(res_valid), 32'd0);
        end
        run_job({8'd2, 8'd3, 8'd4, 8'd5}, {8'd6, 8'd7, 8'd8, 8'd9}, 0);

        // Randomized jobs with random downstream stalls.
        for (int n = 0; n < 25; n++) begin
            run_job($urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
